// File: rtl/gray2rgb_pkg.sv
// rtl/gray2rgb_pkg.sv - shared mode, segment and channel constants for gray2rgb
//
// Contents:
//   mode_e      : output colour mode (MODE_GRAY replicate, MODE_HEAT heatmap)
//   SEG_B1..3   : gray8 thresholds that split the heatmap into four ramps
//   R/G/B_LSB   : byte offsets of each channel inside the 24-bit output word
//   stage_a_t   : payload held between the clamp stage and the colour stage
package gray2rgb_pkg;

  typedef enum logic {
    MODE_GRAY = 1'b0,
    MODE_HEAT = 1'b1
  } mode_e;

  localparam logic [7:0] SEG_B1 = 8'd64;
  localparam logic [7:0] SEG_B2 = 8'd128;
  localparam logic [7:0] SEG_B3 = 8'd192;

  localparam int R_LSB = 0;
  localparam int G_LSB = 8;
  localparam int B_LSB = 16;

  typedef struct packed {
    logic [7:0] gray8;
    mode_e      mode;
    logic       tuser;
    logic       tlast;
  } stage_a_t;

endpackage

// File: rtl/gray2rgb_axis_skid_buf.sv
// rtl/gray2rgb_axis_skid_buf.sv - one-entry input skid buffer with registered ready
//
// Ports:
//   pixel_clk, rst_n                    : clock, async active-low reset
//   s_axis_tvalid/tready/tdata/tuser/tlast : upstream stream (tready registered)
//   m_axis_tvalid/tready/tdata/tuser/tlast : downstream side; m_axis_tready is the
//                                           consumer's advance enable
// The downstream side is a pass-through of the live input while the skid is
// empty, so an unstalled beat adds no latency here.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast
);

  logic             skid_full;
  logic             skid_full_nxt;
  logic             s_ready_q;
  logic             in_fire;
  logic [WIDTH-1:0] skid_tdata;
  logic             skid_tuser;
  logic             skid_tlast;

  assign s_axis_tready = s_ready_q;
  assign in_fire       = s_axis_tvalid && s_ready_q;

  // A full skid always wins so that the older beat leaves first.
  assign m_axis_tvalid = skid_full || in_fire;
  assign m_axis_tdata  = skid_full ? skid_tdata : s_axis_tdata;
  assign m_axis_tuser  = skid_full ? skid_tuser : s_axis_tuser;
  assign m_axis_tlast  = skid_full ? skid_tlast : s_axis_tlast;

  // While full, ready is low, so no new beat can arrive in the same cycle.
  always_comb begin
    skid_full_nxt = skid_full ? !m_axis_tready : (in_fire && !m_axis_tready);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full  <= 1'b0;
      s_ready_q  <= 1'b0;
      skid_tdata <= '0;
      skid_tuser <= 1'b0;
      skid_tlast <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
      s_ready_q <= !skid_full_nxt;
      if (!skid_full && in_fire && !m_axis_tready) begin
        skid_tdata <= s_axis_tdata;
        skid_tuser <= s_axis_tuser;
        skid_tlast <= s_axis_tlast;
      end
    end
  end

endmodule

// File: rtl/gray2rgb.sv
// rtl/gray2rgb.sv - gray AXI-Stream to 24-bit RGB (replicate or heatmap) with backpressure
//
// Ports:
//   pixel_clk, rst_n      : clock, async active-low reset
//   s_axis_tvalid/tready  : input handshake (tready registered, low in reset)
//   s_axis_tdata          : unsigned gray sample, DATA_WIDTH bits, clamped to 255
//   s_axis_tuser/tlast    : start of frame / end of line
//   sel_way               : mode request, taken only on an accepted tuser beat
//   m_axis_tvalid/tready  : output handshake
//   m_axis_tdata          : {B, G, R}
//   m_axis_tuser/tlast    : frame/line markers aligned with their pixel
// Pipeline: skid -> stage A (clamp, mode) -> stage B (colour map, outputs).
module gray2rgb #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  sel_way,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [23:0]           m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast
);

  import gray2rgb_pkg::*;

  logic                  ce;
  logic                  in_fire;
  mode_e                 mode_q;
  mode_e                 beat_mode;

  logic                  sk_tvalid;
  logic [DATA_WIDTH:0]   sk_tdata;
  logic                  sk_tuser;
  logic                  sk_tlast;
  logic [DATA_WIDTH-1:0] sk_gray;
  logic [7:0]            gray8;

  logic                  a_valid;
  stage_a_t              a_q;
  logic [7:0]            ramp;
  logic [23:0]           rgb_nxt;

  assign ce      = m_axis_tready || !m_axis_tvalid;
  assign in_fire = s_axis_tvalid && s_axis_tready;

  // The mode is resolved when the beat is accepted and then rides with the
  // beat, so a beat parked in the skid keeps the mode it arrived under.
  assign beat_mode = s_axis_tuser ? mode_e'(sel_way) : mode_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_GRAY;
    end else if (in_fire && s_axis_tuser) begin
      mode_q <= mode_e'(sel_way);
    end
  end

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  ({beat_mode, s_axis_tdata}),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (sk_tvalid),
    .m_axis_tready (ce),
    .m_axis_tdata  (sk_tdata),
    .m_axis_tuser  (sk_tuser),
    .m_axis_tlast  (sk_tlast)
  );

  assign sk_gray = sk_tdata[DATA_WIDTH-1:0];
  assign gray8   = (sk_gray > DATA_WIDTH'(255)) ? 8'hFF : sk_gray[7:0];

  // Stage A: clamp and mode select.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (ce) begin
      a_valid <= sk_tvalid;
      if (sk_tvalid) begin
        a_q.gray8 <= gray8;
        a_q.mode  <= mode_e'(sk_tdata[DATA_WIDTH]);
        a_q.tuser <= sk_tuser;
        a_q.tlast <= sk_tlast;
      end
    end
  end

  // Each heatmap segment is 64 codes wide, so the in-segment offset times 4
  // is just the low six bits shifted up; its maximum of 252 cannot overflow.
  assign ramp = {a_q.gray8[5:0], 2'b00};

  always_comb begin
    rgb_nxt = '0;
    if (a_q.mode == MODE_GRAY) begin
      rgb_nxt[R_LSB +: 8] = a_q.gray8;
      rgb_nxt[G_LSB +: 8] = a_q.gray8;
      rgb_nxt[B_LSB +: 8] = a_q.gray8;
    end else if (a_q.gray8 < SEG_B1) begin
      rgb_nxt[G_LSB +: 8] = ramp;
      rgb_nxt[B_LSB +: 8] = 8'hFF;
    end else if (a_q.gray8 < SEG_B2) begin
      rgb_nxt[G_LSB +: 8] = 8'hFF;
      rgb_nxt[B_LSB +: 8] = 8'hFF - ramp;
    end else if (a_q.gray8 < SEG_B3) begin
      rgb_nxt[R_LSB +: 8] = ramp;
      rgb_nxt[G_LSB +: 8] = 8'hFF;
    end else begin
      rgb_nxt[R_LSB +: 8] = 8'hFF;
      rgb_nxt[G_LSB +: 8] = 8'hFF - ramp;
    end
  end

  // Stage B: output registers; they only move on ce, which keeps a presented
  // beat stable until the consumer takes it.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (ce) begin
      m_axis_tvalid <= a_valid;
      if (a_valid) begin
        m_axis_tdata <= rgb_nxt;
        m_axis_tuser <= a_q.tuser;
        m_axis_tlast <= a_q.tlast;
      end
    end
  end

endmodule

// File: doc/gray2rgb.md
Name: gray2rgb

Overview:
- Converts a single-channel AXI4-Stream gray pixel stream back into a 24-bit RGB AXI4-Stream for display and debug overlay paths.
- Two output modes:
  - grayscale replicate, where R = G = B = gray;
  - pseudo-colour heatmap (4-segment piecewise-linear blue→cyan→green→yellow→red).
- Sits downstream of the gray-conversion and gray-domain filters.
- Unlike the upstream gray stage, it honours full valid/ready backpressure toward the video output interconnect.

Parameters:
- DATA_WIDTH, 10, width of input gray sample; must be >= 8.

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready (registered).
- s_axis_tdata  in  DATA_WIDTH  gray sample, unsigned.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- sel_way  in  1  mode request: 0 = replicate, 1 = heatmap.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  24  [23:16] = B, [15:8] = G, [7:0] = R.
- m_axis_tuser  out  1  start of frame, aligned with its pixel.
- m_axis_tlast  out  1  end of line, aligned with its pixel.

Behaviour:
- Reset (rst_n low, async):
  - m_axis_tvalid/tuser/tlast = 0, m_axis_tdata = 0.
  - Skid buffer empty; mode register = 0.
  - s_axis_tready = 0 while rst_n low; it is 1 from the first pixel_clk edge after release.
- Reset asserted mid-frame discards every in-flight beat; no partial beat is emitted afterwards.
- Handshake: a beat transfers on an edge where tvalid && tready. m_axis_tvalid, once high, holds with tdata/tuser/tlast stable until m_axis_tready.
- Pipeline enable: ce = m_axis_tready || !m_axis_tvalid.
  - Stage A: clamp and mode select.
  - Stage B: colour map, output registers.
  - Both advance only on ce.
- Latency: a beat accepted in cycle k is presented on m_axis in cycle k+2 when unstalled. Throughput is 1 beat/clk with m_axis_tready held high.
- Skid buffer (input side): s_axis_tready = !skid_full, registered.
  - When ce is low and an input beat arrives, the beat is captured; skid_full = 1.
  - When ce returns, the skid entry is drained first, then live input.
  - No beat is dropped or duplicated under any tready pattern.
- Clamp: gray8 = 255 if s_axis_tdata > 255, else s_axis_tdata[7:0].
- Mode latch:
  - sel_way is sampled only on an accepted beat with s_axis_tuser = 1.
  - That beat and all following beats use the new mode until the next accepted tuser beat.
  - sel_way changes mid-frame have no effect.
  - Mode is 0 after reset until the first tuser.
- Mode 0: R = G = B = gray8.
- Mode 1 (x = gray8):
  - x in 0..63: R = 0, G = 4x, B = 255.
  - x in 64..127: R = 0, G = 255, B = 255 − 4(x−64).
  - x in 128..191: R = 4(x−128), G = 255, B = 0.
  - x in 192..255: R = 255, G = 255 − 4(x−192), B = 0.
  - All results are 8-bit, no overflow (max term 252).
- tuser/tlast travel with their pixel through the skid and both stages.
- Simultaneous tuser and tlast on one beat (1-pixel line) is passed through unchanged.

Decomposition:
- Shared package gray2rgb_pkg:
  - mode constants MODE_GRAY = 0, MODE_HEAT = 1;
  - segment-boundary constants 64/128/192;
  - channel byte offsets R_LSB = 0, G_LSB = 8, B_LSB = 16.
- One sub-module: axis_skid_buf (width parameter; carries tdata, tuser, tlast).
- Colour map stays inline as the stage-B register logic.

Test Plan:
- Mode 0, m_axis_tready = 1, inputs 0x05A then 0x3FF → outputs 0x5A5A5A then 0xFFFFFF (clamped), each 2 cycles after accept, back-to-back.
- sel_way = 1 with tuser beat, then gray 0x040, 0x0C8, 0x000 → 0xFFFF00, 0x00DFFF, 0xFF0000 (B=255, G=0, R=0).
- Mode switch: sel_way toggled to 1 mid-frame → output stays mode 0 until the next tuser beat, which is the first beat in mode 1.
- Backpressure: 64-beat line with m_axis_tready toggling pseudo-randomly, s_axis_tvalid constant → output sequence identical to input order, 64 beats, tlast only on beat 63, s_axis_tready deasserts at most 1 cycle after the stall.
- Reset mid-frame: assert rst_n low with 2 beats in flight → m_axis_tvalid = 0 immediately; after release, the first output is the first post-reset input, mode = 0.
- 1-pixel line: tuser = tlast = 1 on the same beat → both asserted together on the output beat.
